difftest_commit_tracker: RTL

//  Parametrised commit tracker for the difftest path: generalises single-port commit capture to

---
 rtl/difftest_commit_tracker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/difftest_commit_tracker.sv
// rtl/difftest_commit_tracker.sv - multi-slot difftest commit capture with counters, trap and watchdog
module difftest_commit_tracker #(
    parameter int           NCOMMIT        = 2,
    parameter int           XLEN           = 64,
    parameter logic [6:0]   TRAP_OPCODE    = 7'h6b,
    parameter int           TIMEOUT_CYCLES = 5000,
    parameter logic [7:0]   TIMEOUT_CODE   = 8'hff
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCOMMIT-1:0]      wb_valid,
    input  logic [NCOMMIT*XLEN-1:0] wb_pc,
    input  logic [NCOMMIT*32-1:0]   wb_inst,
    input  logic [NCOMMIT-1:0]      wb_rf_we,
    input  logic [NCOMMIT*5-1:0]    wb_rf_wnum,
    input  logic [NCOMMIT*XLEN-1:0] wb_rf_wdata,
    input  logic [XLEN-1:0]         a0_value,
    output logic [NCOMMIT-1:0]      cmt_valid,
    output logic [NCOMMIT-1:0]      cmt_wen,
    output logic [NCOMMIT*8-1:0]    cmt_wdest,
    output logic [NCOMMIT*XLEN-1:0] cmt_wdata,
    output logic [NCOMMIT*XLEN-1:0] cmt_pc,
    output logic [NCOMMIT*32-1:0]   cmt_inst,
    output logic                    trap,
    output logic                    trap_timeout,
    output logic [7:0]              trap_code,
    output logic [XLEN-1:0]         trap_pc,
    output logic [63:0]             cycle_cnt,
    output logic [63:0]             instr_cnt
);

    typedef enum logic {RUN, TRAPPED} state_t;

    state_t                  state_q;
    logic [31:0]             wd_q;
    logic [XLEN-1:0]         last_pc_q;

    logic [NCOMMIT-1:0]      eff_d;
    logic [NCOMMIT-1:0]      wen_d;
    logic [NCOMMIT*8-1:0]    wdest_d;
    logic [NCOMMIT*XLEN-1:0] wdata_d;
    logic [NCOMMIT*XLEN-1:0] pc_d;
    logic [NCOMMIT*32-1:0]   inst_d;
    logic                    trap_hit;
    logic [XLEN-1:0]         trap_pc_d;
    logic [XLEN-1:0]         last_pc_d;
    logic [63:0]             n_eff;
    logic                    timeout_hit;
    logic                    unused_a0;

    assign unused_a0 = ^a0_value[XLEN-1:8];

    // Slots younger than the first trap in a cycle never retire.
    always_comb begin
        eff_d     = '0;
        wen_d     = '0;
        wdest_d   = '0;
        wdata_d   = '0;
        pc_d      = '0;
        inst_d    = '0;
        trap_hit  = 1'b0;
        trap_pc_d = '0;
        last_pc_d = last_pc_q;
        n_eff     = 64'd0;
        for (int i = 0; i < NCOMMIT; i++) begin
            if (wb_valid[i] && !trap_hit) begin
                eff_d[i]              = 1'b1;
                wen_d[i]              = wb_rf_we[i] && (wb_rf_wnum[i*5 +: 5] != 5'd0);
                wdest_d[i*8 +: 8]     = {3'd0, wb_rf_wnum[i*5 +: 5]};
                wdata_d[i*XLEN +: XLEN] = wb_rf_wdata[i*XLEN +: XLEN];
                pc_d[i*XLEN +: XLEN]  = wb_pc[i*XLEN +: XLEN];
                inst_d[i*32 +: 32]    = wb_inst[i*32 +: 32];
                last_pc_d             = wb_pc[i*XLEN +: XLEN];
                n_eff                 = n_eff + 64'd1;
                if (wb_inst[i*32 +: 7] == TRAP_OPCODE) begin
                    trap_hit  = 1'b1;
                    trap_pc_d = wb_pc[i*XLEN +: XLEN];
                end
            end
        end
        timeout_hit = (TIMEOUT_CYCLES != 0) && (n_eff == 64'd0)
                      && ((wd_q + 32'd1) == 32'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            wd_q         <= '0;
            last_pc_q    <= '0;
            cmt_valid    <= '0;
            cmt_wen      <= '0;
            cmt_wdest    <= '0;
            cmt_wdata    <= '0;
            cmt_pc       <= '0;
            cmt_inst     <= '0;
            trap         <= 1'b0;
            trap_timeout <= 1'b0;
            trap_code    <= '0;
            trap_pc      <= '0;
            cycle_cnt    <= '0;
            instr_cnt    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    cmt_valid <= eff_d;
                    cmt_wen   <= wen_d;
                    cmt_wdest <= wdest_d;
                    cmt_wdata <= wdata_d;
                    cmt_pc    <= pc_d;
                    cmt_inst  <= inst_d;
                    cycle_cnt <= cycle_cnt + 64'd1;
                    instr_cnt <= instr_cnt + n_eff;
                    last_pc_q <= last_pc_d;
                    wd_q      <= (n_eff != 64'd0) ? 32'd0 : wd_q + 32'd1;
                    if (trap_hit) begin
                        state_q   <= TRAPPED;
                        trap      <= 1'b1;
                        trap_code <= a0_value[7:0];
                        trap_pc   <= trap_pc_d;
                    end else if (timeout_hit) begin
                        state_q      <= TRAPPED;
                        trap         <= 1'b1;
                        trap_timeout <= 1'b1;
                        trap_code    <= TIMEOUT_CODE;
                        trap_pc      <= last_pc_q;
                    end
                end
                default: begin
                    cmt_valid <= '0;
                    cmt_wen   <= '0;
                    cmt_wdest <= '0;
                    cmt_wdata <= '0;
                    cmt_pc    <= '0;
                    cmt_inst  <= '0;
                end
            endcase
        end
    end

endmodule
